uart_cmd_responder: RTL and testbench

Register-access responder on the byte side of the UART: consumes received bytes (`rx_data`/`new_rx_data`), parses 2- or 3-byte command frames, performs a single read or write on a simple 8-bit register bus, and returns a one-byte reply through the transmitter handshake (`tx_data`/`tx_begin`/`tx_busy`). Sits between the UART top level and the host-visible register file, making the serial link a debug/control port.

---
 rtl/uart_cmd_pkg.sv | 21 ++
 rtl/uart_cmd_timeout.sv | 26 ++
 rtl/uart_cmd_responder.sv | 187 ++++++++++++++++++
 tb/tb_uart_cmd_responder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command responder.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGetAddr,
        StGetData,
        StBus,
        StSend,
        StWaitHi,
        StWaitLo
    } state_e;

    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

    localparam int unsigned WAIT_HI_LIMIT = 4;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Saturating baud-tick counter that flags an abandoned partial frame.
module uart_cmd_timeout #(
    parameter logic [15:0] TIMEOUT_TICKS = 16'd2560
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [15:0] cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= 16'd0;
        end else if (clear) begin
            cnt_q <= 16'd0;
        end else if (enable && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign expire = (cnt_q >= TIMEOUT_TICKS);

endmodule

// File: rtl/uart_cmd_responder.sv
// Parses R/W command frames from the UART, runs one register-bus access, returns a reply byte.
// Optional partial-frame timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_TICKS = 16'd2560
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       new_rx_data,
    input  logic       baud_clk,
    output logic [7:0] tx_data,
    output logic       tx_begin,
    input  logic       tx_busy,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    input  logic       reg_ack,
    output logic       frame_err
);

    state_e     state_q, state_d;
    logic       is_wr_q, is_wr_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_begin_q, tx_begin_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       reg_wr_q, reg_wr_d;
    logic       reg_rd_q, reg_rd_d;
    logic       frame_err_q, frame_err_d;
    logic       err_dly_q, err_dly_d;
    logic [2:0] wait_cnt_q, wait_cnt_d;

    logic in_get;
    logic busy_state;
    logic timeout_expire;

    assign in_get     = (state_q == StGetAddr) || (state_q == StGetData);
    assign busy_state = (state_q == StBus) || (state_q == StSend) ||
                        (state_q == StWaitHi) || (state_q == StWaitLo);

`ifdef UART_CMD_TIMEOUT_EN
    uart_cmd_timeout #(
        .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (new_rx_data | ~in_get),
        .enable (baud_clk & in_get),
        .expire (timeout_expire)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^{baud_clk, TIMEOUT_TICKS};
    assign timeout_expire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        tx_data_d   = tx_data_q;
        tx_begin_d  = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        reg_wr_d    = reg_wr_q;
        reg_rd_d    = reg_rd_q;
        // Unknown-command error is delayed one cycle so it lines up with the reply strobe.
        frame_err_d = err_dly_q;
        err_dly_d   = 1'b0;
        wait_cnt_d  = wait_cnt_q;

        if (new_rx_data && busy_state) begin
            frame_err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (new_rx_data) begin
                    if ((rx_data == CMD_RD) || (rx_data == CMD_WR)) begin
                        is_wr_d = (rx_data == CMD_WR);
                        state_d = StGetAddr;
                    end else begin
                        tx_data_d = RSP_ERR;
                        err_dly_d = 1'b1;
                        state_d   = StSend;
                    end
                end
            end
            StGetAddr: begin
                if (new_rx_data) begin
                    addr_d = rx_data;
                    if (is_wr_q) begin
                        state_d = StGetData;
                    end else begin
                        reg_rd_d = 1'b1;
                        state_d  = StBus;
                    end
                end else if (timeout_expire) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StGetData: begin
                if (new_rx_data) begin
                    wdata_d  = rx_data;
                    reg_wr_d = 1'b1;
                    state_d  = StBus;
                end else if (timeout_expire) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StBus: begin
                if (reg_ack) begin
                    reg_rd_d  = 1'b0;
                    reg_wr_d  = 1'b0;
                    tx_data_d = is_wr_q ? RSP_OK : reg_rdata;
                    state_d   = StSend;
                end
            end
            StSend: begin
                if (!tx_busy) begin
                    tx_begin_d = 1'b1;
                    wait_cnt_d = 3'd0;
                    state_d    = StWaitHi;
                end
            end
            StWaitHi: begin
                if (tx_busy) begin
                    state_d = StWaitLo;
                end else if (wait_cnt_q == 3'(WAIT_HI_LIMIT - 1)) begin
                    state_d = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            StWaitLo: begin
                if (!tx_busy) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            is_wr_q     <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_begin_q  <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            frame_err_q <= 1'b0;
            err_dly_q   <= 1'b0;
            wait_cnt_q  <= 3'd0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            tx_data_q   <= tx_data_d;
            tx_begin_q  <= tx_begin_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            reg_wr_q    <= reg_wr_d;
            reg_rd_q    <= reg_rd_d;
            frame_err_q <= frame_err_d;
            err_dly_q   <= err_dly_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_begin  = tx_begin_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_wr    = reg_wr_q;
    assign reg_rd    = reg_rd_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed self-checking bench for uart_cmd_responder; timeout scenario runs when
// UART_CMD_TIMEOUT_EN is defined.
module tb_uart_cmd_responder;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       new_rx_data = 1'b0;
    logic       baud_clk = 1'b0;
    logic [7:0] tx_data;
    logic       tx_begin;
    logic       tx_busy = 1'b0;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata = 8'h00;
    logic       reg_ack = 1'b0;
    logic       frame_err;

    int n_checks = 0;
    int n_errors = 0;
    int tx_cnt = 0;
    int tx0;

    uart_cmd_responder #(
        .TIMEOUT_TICKS(16'd32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_data     (rx_data),
        .new_rx_data (new_rx_data),
        .baud_clk    (baud_clk),
        .tx_data     (tx_data),
        .tx_begin    (tx_begin),
        .tx_busy     (tx_busy),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_wr      (reg_wr),
        .reg_rd      (reg_rd),
        .reg_rdata   (reg_rdata),
        .reg_ack     (reg_ack),
        .frame_err   (frame_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (tx_begin) tx_cnt <= tx_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data     = b;
        new_rx_data = 1'b1;
        step();
        new_rx_data = 1'b0;
    endtask

    // Called in the cycle tx_begin is high: emulate one transmitter busy window.
    task automatic finish_tx;
        tx_busy = 1'b1;
        step();
        check("tx_begin_one_cycle", 32'(tx_begin), 32'h0);
        repeat (5) step();
        tx_busy = 1'b0;
        step();
        step();
    endtask

    initial begin
        repeat (3) step();
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_tx_begin", 32'(tx_begin), 32'h0);
        check("rst_reg_addr", 32'(reg_addr), 32'h00);
        check("rst_reg_wdata", 32'(reg_wdata), 32'h00);
        check("rst_reg_wr", 32'(reg_wr), 32'h0);
        check("rst_reg_rd", 32'(reg_rd), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        reset = 1'b1;
        step();

        // Write frame
        send_byte(8'h57);
        send_byte(8'h10);
        check("wr_no_err", 32'(frame_err), 32'h0);
        send_byte(8'hA5);
        check("wr_req", 32'(reg_wr), 32'h1);
        check("wr_no_rd", 32'(reg_rd), 32'h0);
        check("wr_addr", 32'(reg_addr), 32'h10);
        check("wr_wdata", 32'(reg_wdata), 32'hA5);
        repeat (3) step();
        check("wr_held", 32'(reg_wr), 32'h1);
        tx0 = tx_cnt;
        reg_ack = 1'b1;
        step();
        reg_ack = 1'b0;
        check("wr_drop", 32'(reg_wr), 32'h0);
        check("wr_send_entry", 32'(tx_begin), 32'h0);
        step();
        check("wr_tx_begin", 32'(tx_begin), 32'h1);
        check("wr_tx_data", 32'(tx_data), 32'h4B);
        finish_tx();
        check("wr_one_reply", 32'(tx_cnt - tx0), 32'h1);

        // Read frame, ack after 3 cycles
        send_byte(8'h52);
        send_byte(8'h22);
        check("rd_req", 32'(reg_rd), 32'h1);
        check("rd_addr", 32'(reg_addr), 32'h22);
        check("rd_no_wr", 32'(reg_wr), 32'h0);
        step();
        step();
        reg_rdata = 8'h5C;
        reg_ack   = 1'b1;
        step();
        reg_ack = 1'b0;
        check("rd_drop", 32'(reg_rd), 32'h0);
        step();
        check("rd_tx_begin", 32'(tx_begin), 32'h1);
        check("rd_tx_data", 32'(tx_data), 32'h5C);
        finish_tx();

        // Unknown command
        send_byte(8'h41);
        check("unk_err_early", 32'(frame_err), 32'h0);
        check("unk_tx_early", 32'(tx_begin), 32'h0);
        step();
        check("unk_err", 32'(frame_err), 32'h1);
        check("unk_tx_begin", 32'(tx_begin), 32'h1);
        check("unk_tx_data", 32'(tx_data), 32'h3F);
        check("unk_no_rd", 32'(reg_rd), 32'h0);
        check("unk_no_wr", 32'(reg_wr), 32'h0);
        finish_tx();
        check("unk_err_clear", 32'(frame_err), 32'h0);

        // Overrun while in BUS
        send_byte(8'h52);
        send_byte(8'h44);
        send_byte(8'h33);
        check("ovr_err", 32'(frame_err), 32'h1);
        check("ovr_rd_held", 32'(reg_rd), 32'h1);
        check("ovr_addr", 32'(reg_addr), 32'h44);
        step();
        check("ovr_err_pulse", 32'(frame_err), 32'h0);
        reg_rdata = 8'h99;
        reg_ack   = 1'b1;
        step();
        reg_ack = 1'b0;
        step();
        check("ovr_tx_begin", 32'(tx_begin), 32'h1);
        check("ovr_tx_data", 32'(tx_data), 32'h99);
        finish_tx();

        // Transmitter busy at SEND entry
        send_byte(8'h57);
        send_byte(8'h01);
        send_byte(8'h02);
        tx_busy = 1'b1;
        reg_ack = 1'b1;
        step();
        reg_ack = 1'b0;
        tx0 = tx_cnt;
        for (int i = 0; i < 50; i++) begin
            step();
            check("busy_no_begin", 32'(tx_begin), 32'h0);
            check("busy_tx_data", 32'(tx_data), 32'h4B);
        end
        tx_busy = 1'b0;
        step();
        check("busy_begin", 32'(tx_begin), 32'h1);
        check("busy_tx_data_out", 32'(tx_data), 32'h4B);
        check("busy_no_early", 32'(tx_cnt - tx0), 32'h0);
        finish_tx();

        // tx_busy never rises: WAIT_HI gives up after 4 cycles
        send_byte(8'h41);
        step();
        check("whi_begin", 32'(tx_begin), 32'h1);
        repeat (4) step();
        send_byte(8'h52);
        check("whi_no_err", 32'(frame_err), 32'h0);
        send_byte(8'h66);
        check("whi_rd", 32'(reg_rd), 32'h1);
        check("whi_addr", 32'(reg_addr), 32'h66);
        reg_rdata = 8'h17;
        reg_ack   = 1'b1;
        step();
        reg_ack = 1'b0;
        step();
        check("whi_tx_data", 32'(tx_data), 32'h17);
        finish_tx();

`ifdef UART_CMD_TIMEOUT_EN
        // Partial write abandoned after 32 ticks
        baud_clk = 1'b1;
        tx0 = tx_cnt;
        send_byte(8'h57);
        send_byte(8'h10);
        repeat (32) step();
        check("to_not_yet", 32'(frame_err), 32'h0);
        step();
        check("to_err", 32'(frame_err), 32'h1);
        step();
        check("to_err_pulse", 32'(frame_err), 32'h0);
        check("to_no_wr", 32'(reg_wr), 32'h0);
        repeat (4) step();
        check("to_no_reply", 32'(tx_cnt - tx0), 32'h0);
        baud_clk = 1'b0;
        send_byte(8'h52);
        send_byte(8'h10);
        check("to_rd", 32'(reg_rd), 32'h1);
        check("to_rd_addr", 32'(reg_addr), 32'h10);
        reg_rdata = 8'hC3;
        reg_ack   = 1'b1;
        step();
        reg_ack = 1'b0;
        step();
        check("to_tx_begin", 32'(tx_begin), 32'h1);
        check("to_tx_data", 32'(tx_data), 32'hC3);
        finish_tx();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
